sevenseg_decoder: RTL

SEVENSEG_DECODER -- requirements
Module: sevenseg_decoder

---
 rtl/sevenseg_pkg.sv | 59 +++++
 rtl/sevenseg_lut_inv.sv | 31 +++
 rtl/sevenseg_decoder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
// Shared definitions for seven-segment encode/decode logic.
//   - SEG_0 .. SEG_F : active-high segment patterns, bit 6 = g ... bit 0 = a
//   - SEG_BLANK      : all segments off
//   - dec_state_t    : decoder FSM states
//   - seg_encode()   : nibble -> pattern; the single table used by both
//                      encoders and the decoder's inverse lookup
// -----------------------------------------------------------------------------
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b1011000;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        SETTLE    = 2'd1,
        HOLD      = 2'd2
    } dec_state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = SEG_0;
            4'h1:    pat = SEG_1;
            4'h2:    pat = SEG_2;
            4'h3:    pat = SEG_3;
            4'h4:    pat = SEG_4;
            4'h5:    pat = SEG_5;
            4'h6:    pat = SEG_6;
            4'h7:    pat = SEG_7;
            4'h8:    pat = SEG_8;
            4'h9:    pat = SEG_9;
            4'hA:    pat = SEG_A;
            4'hB:    pat = SEG_B;
            4'hC:    pat = SEG_C;
            4'hD:    pat = SEG_D;
            4'hE:    pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/sevenseg_lut_inv.sv
// -----------------------------------------------------------------------------
// sevenseg_lut_inv
// Combinational inverse of the seven-segment table.
//   seg    [6:0] in  : active-high segment pattern (bit 6 = g ... bit 0 = a)
//   nibble [3:0] out : decoded hex digit (0 when hit = 0)
//   hit          out : 1 when seg matches one of the 16 table entries
// -----------------------------------------------------------------------------
module sevenseg_lut_inv
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       hit
);

    // Search the shared encode table so the inverse can never drift from it.
    // All 16 patterns are distinct, so at most one iteration matches.
    always_comb begin
        // NOTE: every output gets a default before any conditional assignment;
        // a path that leaves a combinational output unassigned infers a latch.
        nibble = 4'h0;
        hit    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == seg_encode(4'(i))) begin
                nibble = 4'(i);
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sevenseg_decoder.sv
// -----------------------------------------------------------------------------
// sevenseg_decoder
// Recovers two hex digits from a multiplexed seven-segment drive.
//   clk              in  : block clock, rising edge
//   rst_n            in  : synchronous active-low reset
//   seg        [6:0] in  : segment pattern, bit 6 = g ... bit 0 = a
//   seg_tg           in  : digit select, 1 = high digit, 0 = low digit
//   digit_hi   [3:0] out : last decoded high digit
//   digit_lo   [3:0] out : last decoded low digit
//   pair_valid       out : one-cycle pulse, a hi-then-lo pair has completed
//   pat_err          out : one-cycle pulse, captured pattern not in the table
//   stalled          out : level, no seg_tg edge for TIMEOUT_CYCLES cycles
//   err_cnt    [7:0] out : saturating count of pat_err pulses
//                          (present only when SEVENSEG_DEC_ERRCNT_EN is defined)
// Parameters:
//   STABLE_CYCLES  : cycles a pattern must stay unchanged before capture
//   TIMEOUT_CYCLES : cycles without a seg_tg edge before stalled asserts
// -----------------------------------------------------------------------------
module sevenseg_decoder
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic       seg_tg,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo,
    output logic       pair_valid,
    output logic       pat_err,
    output logic       stalled
`ifdef SEVENSEG_DEC_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int STAB_W  = $clog2(STABLE_CYCLES + 1);
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STAB_W-1:0]  STAB_MAX  = STAB_W'(STABLE_CYCLES);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT_CYCLES);

    // Synchronizers plus one extra stage of each for change/edge detection.
    logic [6:0]         seg_meta_q, seg_sync_q, seg_prev_q;
    logic               tg_meta_q, tg_sync_q, tg_prev_q;

    dec_state_t         state_q, state_d;
    logic               phase_q, phase_d;          // 1 = capturing high digit
    logic [STAB_W-1:0]  stab_cnt_q, stab_cnt_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [3:0]         digit_hi_q, digit_hi_d;
    logic [3:0]         digit_lo_q, digit_lo_d;
    logic               armed_q, armed_d;          // hi captured, waiting for lo
    logic               pair_valid_q, pair_valid_d;
    logic               pat_err_q, pat_err_d;

    logic               tg_edge;
    logic               capture;
    logic [STAB_W-1:0]  stab_next;
    logic [3:0]         lut_nibble;
    logic               lut_hit;

    assign tg_edge = tg_sync_q ^ tg_prev_q;

    sevenseg_lut_inv u_lut_inv (
        .seg    (seg_sync_q),
        .nibble (lut_nibble),
        .hit    (lut_hit)
    );

    // Counts the current cycle as the first of a new pattern when it differs
    // from the previous one, so capture happens on the STABLE_CYCLES-th
    // consecutive cycle showing the same pattern.
    always_comb begin
        if (seg_sync_q != seg_prev_q) begin
            stab_next = STAB_W'(1);
        end else if (stab_cnt_q == STAB_MAX) begin
            stab_next = STAB_MAX;
        end else begin
            stab_next = stab_cnt_q + STAB_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        stab_cnt_d   = stab_cnt_q;
        digit_hi_d   = digit_hi_q;
        digit_lo_d   = digit_lo_q;
        armed_d      = armed_q;
        pair_valid_d = 1'b0;
        pat_err_d    = 1'b0;
        capture      = 1'b0;

        // An edge wins in every state: it opens a fresh SETTLE for the new
        // phase and silently drops anything pending from the old one.
        if (tg_edge) begin
            state_d    = SETTLE;
            phase_d    = tg_sync_q;
            stab_cnt_d = '0;
        end else begin
            case (state_q)
                SETTLE: begin
                    stab_cnt_d = stab_next;
                    if (stab_next == STAB_MAX) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end
                WAIT_EDGE, HOLD: state_d = state_q;
                default:         state_d = WAIT_EDGE;
            endcase
        end

        if (capture) begin
            if (!lut_hit) begin
                pat_err_d = 1'b1;
            end else if (phase_q) begin
                digit_hi_d = lut_nibble;
                armed_d    = 1'b1;
            end else begin
                digit_lo_d = lut_nibble;
                if (armed_q) begin
                    pair_valid_d = 1'b1;
                    armed_d      = 1'b0;
                end
            end
        end
    end

    always_comb begin
        if (tg_edge) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q == STALL_MAX) begin
            stall_cnt_d = STALL_MAX;
        end else begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every flop samples
        // the pre-edge value of the others; the synchronizer chain relies on it.
        if (!rst_n) begin
            seg_meta_q   <= SEG_BLANK;
            seg_sync_q   <= SEG_BLANK;
            seg_prev_q   <= SEG_BLANK;
            tg_meta_q    <= 1'b0;
            tg_sync_q    <= 1'b0;
            tg_prev_q    <= 1'b0;
            state_q      <= WAIT_EDGE;
            phase_q      <= 1'b0;
            stab_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            digit_hi_q   <= 4'h0;
            digit_lo_q   <= 4'h0;
            armed_q      <= 1'b0;
            pair_valid_q <= 1'b0;
            pat_err_q    <= 1'b0;
        end else begin
            seg_meta_q   <= seg;
            seg_sync_q   <= seg_meta_q;
            seg_prev_q   <= seg_sync_q;
            tg_meta_q    <= seg_tg;
            tg_sync_q    <= tg_meta_q;
            tg_prev_q    <= tg_sync_q;
            state_q      <= state_d;
            phase_q      <= phase_d;
            stab_cnt_q   <= stab_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            digit_hi_q   <= digit_hi_d;
            digit_lo_q   <= digit_lo_d;
            armed_q      <= armed_d;
            pair_valid_q <= pair_valid_d;
            pat_err_q    <= pat_err_d;
        end
    end

    assign digit_hi   = digit_hi_q;
    assign digit_lo   = digit_lo_q;
    assign pair_valid = pair_valid_q;
    assign pat_err    = pat_err_q;
    // Gated by the live edge so the flag drops in the same cycle the edge
    // is seen rather than one cycle later when the counter clears.
    assign stalled    = (stall_cnt_q == STALL_MAX) && !tg_edge;

`ifdef SEVENSEG_DEC_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (pat_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
